// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit
//  Description : Multi-cycle multiply/divide unit owning the HI/LO registers,
//                with mthi/mtlo writes and a busy/stall interface for hazards.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDOp,
    input  logic        start,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    localparam logic [2:0] c_op_mult  = 3'd1;
    localparam logic [2:0] c_op_multu = 3'd2;
    localparam logic [2:0] c_op_div   = 3'd3;
    localparam logic [2:0] c_op_divu  = 3'd4;
    localparam logic [2:0] c_op_mthi  = 3'd5;
    localparam logic [2:0] c_op_mtlo  = 3'd6;

    localparam logic [3:0] c_mult_load = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] c_div_load  = 4'(DIV_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_count;
    logic [31:0] r_res_hi;
    logic [31:0] r_res_lo;
    logic        r_div0;

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_issue;
    logic        w_div0;
    logic        w_div_ovf;
    logic [31:0] w_divisor;
    logic signed [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic signed [31:0] w_quo_s;
    logic signed [31:0] w_rem_s;
    logic [31:0] w_quo_u;
    logic [31:0] w_rem_u;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_is_mul  = (MDOp == c_op_mult) || (MDOp == c_op_multu);
    assign w_is_div  = (MDOp == c_op_div)  || (MDOp == c_op_divu);
    assign w_issue   = start && (w_is_mul || w_is_div);
    assign w_div0    = (B == 32'd0);
    assign w_div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

    // A zero divisor is replaced so the dividers never see it; that result is discarded.
    assign w_divisor = w_div0 ? 32'd1 : B;

    assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_prod_u = {32'd0, A} * {32'd0, B};
    assign w_quo_s  = $signed(A) / $signed(w_divisor);
    assign w_rem_s  = $signed(A) % $signed(w_divisor);
    assign w_quo_u  = A / w_divisor;
    assign w_rem_u  = A % w_divisor;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (MDOp)
            c_op_mult:  {w_res_hi, w_res_lo} = w_prod_s;
            c_op_multu: {w_res_hi, w_res_lo} = w_prod_u;
            c_op_div: begin
                if (w_div_ovf) begin
                    w_res_hi = 32'd0;
                    w_res_lo = 32'h8000_0000;
                end else begin
                    w_res_hi = w_rem_s;
                    w_res_lo = w_quo_s;
                end
            end
            c_op_divu: begin
                w_res_hi = w_rem_u;
                w_res_lo = w_quo_u;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_count  <= 4'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
            r_div0   <= 1'b0;
            busy     <= 1'b0;
            HI       <= 32'd0;
            LO       <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_res_hi <= w_res_hi;
                        r_res_lo <= w_res_lo;
                        r_div0   <= w_is_div && w_div0;
                        r_state  <= w_is_mul ? ST_MUL : ST_DIV;
                        r_count  <= w_is_mul ? c_mult_load : c_div_load;
                        busy     <= 1'b1;
                    end else if (MDOp == c_op_mthi) begin
                        HI <= A;
                    end else if (MDOp == c_op_mtlo) begin
                        LO <= A;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (r_count != 4'd0) begin
                        r_count <= r_count - 4'd1;
                    end else begin
                        if (!r_div0) begin
                            HI <= r_res_hi;
                            LO <= r_res_lo;
                        end
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign stall = start | busy;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_unit
//  Description : Self-checking bench for md_unit using an expected-result queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDOp;
    logic        start;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;
    logic [63:0] sbq[$];
    logic        prev_busy = 1'b0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .MDOp  (MDOp),
        .start (start),
        .busy  (busy),
        .stall (stall),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
        $fatal(1);
    end

    // Completion monitor: on the first low cycle after a busy window, HI/LO must match the queue head.
    always @(negedge clk) begin
        logic [63:0] exp;
        if (!reset) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !busy) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL completion_unexpected: got HI=%h LO=%h, required no completion", HI, LO);
                end else begin
                    exp = sbq.pop_front();
                    if ({HI, LO} !== exp) begin
                        errors++;
                        $display("FAIL completion_hilo: got HI=%h LO=%h, required HI=%h LO=%h",
                                 HI, LO, exp[63:32], exp[31:0]);
                    end
                end
            end
            prev_busy = busy;
        end
    end

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        model = 64'd0;
        case (op)
            3'd1: begin p = 64'(sa * sb); model = p; end
            3'd2: model = {32'd0, a} * {32'd0, b};
            3'd3: begin
                q = sa / sb;
                r = sa % sb;
                model = {r[31:0], q[31:0]};
            end
            3'd4: model = {a % b, a / b};
            default: ;
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; MDOp = op; A = a; B = b;
        @(negedge clk);
        start = 1'b0; MDOp = 3'd0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic move_to(input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        MDOp = op; A = a;
        @(negedge clk);
        MDOp = 3'd0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; MDOp = 3'd0; A = '0; B = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b stall=%b HI=%h LO=%h, required 0 0 0 0", busy, stall, HI, LO);
        end
        reset = 1'b1;
        move_to(3'd5, 32'h0000_1111);
        checks++;
        if (HI !== 32'h0000_1111) begin
            errors++;
            $display("FAIL reset_pre_mthi: got HI=%h, required 00001111", HI);
        end
        // Aborted divide: no expectation is queued.
        issue(3'd4, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset_abort: got busy=%b HI=%h LO=%h, required 0 0 0", busy, HI, LO);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset_no_late_write: got busy=%b HI=%h LO=%h, required 0 0 0", busy, HI, LO);
        end
    endtask

    task automatic test_mult();
        int n;
        sbq.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFA});
        issue(3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_idle(n);
        checks++;
        if (n != 5) begin errors++; $display("FAIL mult_busy_len: got %0d, required 5", n); end
        sbq.push_back({32'h0000_0002, 32'hFFFF_FFFA});
        issue(3'd2, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_idle(n);
        checks++;
        if (n != 5) begin errors++; $display("FAIL multu_busy_len: got %0d, required 5", n); end
    endtask

    task automatic test_div();
        int n;
        sbq.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        checks++;
        if (n != 10) begin errors++; $display("FAIL div_busy_len: got %0d, required 10", n); end
        sbq.push_back({32'd1, 32'd3});
        issue(3'd4, 32'd7, 32'd2);
        wait_idle(n);
        checks++;
        if (n != 10) begin errors++; $display("FAIL divu_busy_len: got %0d, required 10", n); end
    endtask

    task automatic test_edge_div();
        int n;
        sbq.push_back({32'd0, 32'h8000_0000});
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        move_to(3'd5, 32'h0000_1234);
        move_to(3'd6, 32'h0000_5678);
        checks++;
        if (HI !== 32'h0000_1234 || LO !== 32'h0000_5678) begin
            errors++;
            $display("FAIL mthi_mtlo: got HI=%h LO=%h, required 00001234 00005678", HI, LO);
        end
        sbq.push_back({32'h0000_1234, 32'h0000_5678});
        issue(3'd4, 32'hDEAD_BEEF, 32'd0);
        wait_idle(n);
        checks++;
        if (n != 10) begin errors++; $display("FAIL div0_busy_len: got %0d, required 10", n); end
    endtask

    task automatic test_mtx_gating();
        int n;
        sbq.push_back({32'd0, 32'd30});
        issue(3'd1, 32'd5, 32'd6);
        MDOp = 3'd6; A = 32'hAAAA_0000;
        @(negedge clk);
        MDOp = 3'd0;
        wait_idle(n);
        checks++;
        if (n != 4) begin errors++; $display("FAIL gated_busy_len: got %0d, required 4", n); end
        MDOp = 3'd6; A = 32'hAAAA_0000;
        @(negedge clk);
        MDOp = 3'd0;
        checks++;
        if (LO !== 32'hAAAA_0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo_idle: got LO=%h busy=%b, required aaaa0000 0", LO, busy);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        start = 1'b1; MDOp = 3'd1; A = 32'd3; B = 32'd4;
        sbq.push_back({32'd0, 32'd12});
        #1;
        checks++;
        if (stall !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_issue_stall1: got stall=%b busy=%b, required 1 0", stall, busy);
        end
        @(negedge clk);
        start = 1'b0; MDOp = 3'd0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            checks++;
            if (stall !== 1'b1) begin errors++; $display("FAIL b2b_busy_stall1: got %b, required 1", stall); end
            n++;
            if (n == 2) begin start = 1'b1; MDOp = 3'd3; A = 32'd99; B = 32'd1; end
            else begin start = 1'b0; MDOp = 3'd0; end
            @(negedge clk);
        end
        checks++;
        if (n != 5) begin errors++; $display("FAIL b2b_mult_len: got %0d, required 5", n); end
        start = 1'b1; MDOp = 3'd3; A = 32'd100; B = 32'd7;
        sbq.push_back({32'd2, 32'd14});
        #1;
        checks++;
        if (stall !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_issue_stall2: got stall=%b busy=%b, required 1 0", stall, busy);
        end
        @(negedge clk);
        start = 1'b0; MDOp = 3'd0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            checks++;
            if (stall !== 1'b1) begin errors++; $display("FAIL b2b_busy_stall2: got %b, required 1", stall); end
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 10) begin errors++; $display("FAIL b2b_div_len: got %0d, required 10", n); end
    endtask

    task automatic test_random();
        int n;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(1, 4));
            a  = $urandom();
            b  = (i % 2 == 0) ? $urandom() : 32'($urandom_range(1, 50));
            if (b == 32'd0) b = 32'd3;
            sbq.push_back(model(op, a, b));
            issue(op, a, b);
            wait_idle(n);
            checks++;
            if (n != ((op <= 3'd2) ? 5 : 10)) begin
                errors++;
                $display("FAIL random_busy_len: op=%0d got %0d", op, n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_edge_div();
        test_mtx_gating();
        test_back_to_back();
        test_random();
        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit for the pipelined CPU, placed in the EX stage beside the ALU.
- Sequences mult/multu/div/divu over a fixed cycle count and owns the HI/LO registers.
- Services mthi/mtlo writes.
- Exports busy/stall so hazard control holds any MD-class instruction in D while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- A  in  32  operand rs (dividend / multiplicand / mthi/mtlo source)
- B  in  32  operand rt (divisor / multiplier)
- MDOp  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- start  in  1  EX-stage instruction is mult/multu/div/divu; qualifies MDOp 1..4
- busy  out  1  registered; high while an operation is counting
- stall  out  1  combinational = start | busy; hazard unit stalls D-stage MD instructions on it
- HI  out  32  HI register
- LO  out  32  LO register

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0.
  - busy=0, HI=0, LO=0.
  - Any in-flight operation is aborted; no HI/LO write occurs.
- States:
  - IDLE: waiting.
  - MUL: counting a multiply.
  - DIV: counting a divide.
- Issue:
  - In IDLE with start=1 and MDOp 1..4, the operands are latched at the clock edge.
  - The 64-bit result is computed from the latched operands and held in an internal register {res_hi, res_lo}.
  - State moves to MUL (MDOp 1,2) or DIV (MDOp 3,4).
  - counter loads MULT_CYCLES-1 or DIV_CYCLES-1.
  - busy=1 from the next cycle.
- Counting:
  - Each cycle in MUL/DIV with counter≠0, counter decrements.
  - On the edge where counter==0: HI<=res_hi, LO<=res_lo, busy<=0, state<=IDLE.
  - busy is therefore high for exactly MULT_CYCLES / DIV_CYCLES cycles.
  - HI/LO hold their new values in the first cycle busy is low.
- start while busy=1: ignored; the hazard unit guarantees it does not occur, and the bench checks it is harmless.
- Arithmetic:
  - mult: signed 32x32→64, {HI,LO}=product.
  - multu: unsigned 32x32→64.
  - div: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned; LO=quotient, HI=remainder.
  - Overflow case 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
  - Divide by zero (B=0, div or divu): the operation still runs the full DIV_CYCLES busy window, but HI/LO are left unchanged at completion.
- mthi/mtlo:
  - When busy=0, MDOp=5 writes HI<=A and MDOp=6 writes LO<=A at the clock edge.
  - They take one cycle and never assert busy.
  - Both are ignored when busy=1.
  - start is never high for MDOp 5/6.
- Simultaneous events:
  - Completion edge plus a new start in the same cycle cannot occur, because busy=1 blocks it.
  - A start arriving in the first cycle after completion is accepted normally.
- HI/LO are readable every cycle; mfhi/mflo are held off by stall, so the values are always final when read.
- stall is combinational and has no register; it asserts in the issue cycle itself (start=1, busy=0).

Test Plan:
- Reset: hold reset=0 during mid-DIV (counter=4) → busy drops immediately, HI=LO=0; after release, HI/LO remain 0 with no late write.
- mult: A=0xFFFFFFFE (-2), B=0x00000003, start=1 → busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div: A=0xFFFFFFF9 (-7), B=2 → busy high 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); divu A=7, B=2 → LO=3, HI=1.
- Edge divides:
  - A=0x80000000, B=0xFFFFFFFF with div → LO=0x80000000, HI=0.
  - divu with B=0 after mthi 0x1234/mtlo 0x5678 → busy 10 cycles, then HI=0x1234, LO=0x5678 unchanged.
- mthi/mtlo gating: mtlo A=0xAAAA0000 while busy (mult running) → ignored, LO becomes the mult result; mtlo issued when idle → LO=0xAAAA0000 next cycle, busy stays 0.
- Back-to-back and stall: start mult, then start div one cycle after busy falls → second op accepted, busy windows 5 then 10 cycles with a single-cycle gap; stall=1 in each issue cycle and throughout busy; a start asserted during busy leaves HI/LO and the counter unaffected.
